// File: rtl/mesh_router_buf_pkg.sv
// Shared definitions for the mesh_router_buf router slice.
//  - Port index enumeration (W,E,N,S,L) and port count.
//  - Default flit/coordinate widths.
//  - XY dimension-order route helper and round-robin pointer advance.
package mesh_router_buf_pkg;

  localparam int unsigned NUM_PORTS      = 5;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_COORD_W    = 4;

  typedef enum logic [2:0] {
    PORT_W = 3'd0,
    PORT_E = 3'd1,
    PORT_N = 3'd2,
    PORT_S = 3'd3,
    PORT_L = 3'd4
  } port_e;

  // X is resolved before Y. Comparisons are unsigned, so destinations
  // outside the mesh are routed toward the nearest edge.
  function automatic port_e xy_route(input int unsigned dst_x,
                                     input int unsigned dst_y,
                                     input int unsigned id_x,
                                     input int unsigned id_y);
    if (dst_x > id_x)      return PORT_E;
    else if (dst_x < id_x) return PORT_W;
    else if (dst_y > id_y) return PORT_S;
    else if (dst_y < id_y) return PORT_N;
    else                   return PORT_L;
  endfunction

  // Pointer to the port after the winner, wrapping at NUM_PORTS.
  function automatic logic [2:0] rr_next(input logic [2:0] p);
    return (p >= 3'(NUM_PORTS - 1)) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/mesh_router_buf_in_fifo.sv
// router_in_fifo: synchronous single-clock FIFO used at each router input.
//  clk_i   clock            rst_ni  async active-low reset (empties FIFO)
//  push_i  write request    data_i  write data (DW bits)
//  pop_i   read request     data_o  head-of-queue data (valid when !empty_o)
//  full_o  count == DEPTH   empty_o count == 0
// Pushes while full and pops while empty are ignored. DEPTH must be a power
// of two so the pointers wrap naturally.
module router_in_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/mesh_router_buf.sv
// mesh_router_buf: 5-port (W,E,N,S,L) 2D-mesh router tile, single-flit packets.
//  Each input has a router_in_fifo; the head flit is XY-routed to one output.
//  Each output has a round-robin arbiter feeding an output register.
// Ports (port p occupies bus slice [p*DATA_WIDTH +: DATA_WIDTH]):
//  CDCLK     clock                 CDRESETn  async active-low reset
//  CDIDATA   input flits           CDIVALID  input valid     CDIREADY  input ready
//  CDODATA   output flits          CDOVALID  output valid    CDOREADY  output ready
// Optional (macro MESH_ROUTER_PERF_EN defined):
//  CDPERFFLIT  5x32 saturating flit counters (CDOVALID & CDOREADY)
//  CDPERFSTALL 5x32 saturating stall counters (CDOVALID & !CDOREADY)
//  CDPERFCLR   synchronous clear, takes priority over counting
// Flit header: dest X = flit[DW-1 -: COORD_W], dest Y = next COORD_W bits below.
module mesh_router_buf
  import mesh_router_buf_pkg::*;
#(
  parameter int unsigned ROUTER_ID_X = 0,
  parameter int unsigned ROUTER_ID_Y = 0,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned COORD_W     = DEF_COORD_W,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                            CDCLK,
  input  logic                            CDRESETn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] CDIDATA,
  input  logic [NUM_PORTS-1:0]            CDIVALID,
  output logic [NUM_PORTS-1:0]            CDIREADY,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] CDODATA,
  output logic [NUM_PORTS-1:0]            CDOVALID,
  input  logic [NUM_PORTS-1:0]            CDOREADY
`ifdef MESH_ROUTER_PERF_EN
  ,
  output logic [NUM_PORTS*32-1:0]         CDPERFFLIT,
  output logic [NUM_PORTS*32-1:0]         CDPERFSTALL,
  input  logic                            CDPERFCLR
`endif
);

  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] head;
  logic [NUM_PORTS-1:0]                 full;
  logic [NUM_PORTS-1:0]                 empty;
  logic [NUM_PORTS-1:0]                 pop;
  logic [NUM_PORTS-1:0][2:0]            route;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  gnt;   // gnt[output][input]

  // Ready comes from the registered count only and is forced low in reset.
  assign CDIREADY = ~full & {NUM_PORTS{CDRESETn}};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    router_in_fifo #(
      .DW    (DATA_WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (CDCLK),
      .rst_ni  (CDRESETn),
      .push_i  (CDIVALID[p]),
      .data_i  (CDIDATA[p*DATA_WIDTH +: DATA_WIDTH]),
      .pop_i   (pop[p]),
      .data_o  (head[p]),
      .full_o  (full[p]),
      .empty_o (empty[p])
    );

    assign route[p] = xy_route(32'(head[p][DATA_WIDTH-1 -: COORD_W]),
                               32'(head[p][DATA_WIDTH-1-COORD_W -: COORD_W]),
                               ROUTER_ID_X, ROUTER_ID_Y);
  end

  // Each input requests a single output, so at most one grant per input.
  always_comb begin
    pop = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      pop = pop | gnt[o];
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [2:0]            rr_q, rr_d;
    logic [NUM_PORTS-1:0]  req;
    logic [NUM_PORTS-1:0]  gnt_l;
    logic [2:0]            idx;
    logic [2:0]            win;
    logic                  hit;
    logic                  free;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    always_comb begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        req[p] = ~empty[p] & (route[p] == 3'(o));
      end
    end

    // Scan from rr_q upward (mod NUM_PORTS); the first requester wins.
    always_comb begin
      idx     = '0;
      win     = rr_q;
      hit     = 1'b0;
      gnt_l   = '0;
      rr_d    = rr_q;
      valid_d = valid_q;
      data_d  = data_q;
      free    = ~valid_q | CDOREADY[o];
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        idx = 3'((32'(rr_q) + k) % NUM_PORTS);
        if (!hit && req[idx]) begin
          hit = 1'b1;
          win = idx;
        end
      end
      if (free) begin
        valid_d = hit;
        if (hit) begin
          gnt_l[win] = 1'b1;
          data_d     = head[win];
          rr_d       = rr_next(win);
        end
      end
    end

    always_ff @(posedge CDCLK or negedge CDRESETn) begin
      if (!CDRESETn) begin
        rr_q    <= '0;
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        rr_q    <= rr_d;
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign gnt[o]                                 = gnt_l;
    assign CDOVALID[o]                            = valid_q;
    assign CDODATA[o*DATA_WIDTH +: DATA_WIDTH]    = data_q;

`ifdef MESH_ROUTER_PERF_EN
    logic [31:0] flit_q, stall_q;

    always_ff @(posedge CDCLK or negedge CDRESETn) begin
      if (!CDRESETn) begin
        flit_q  <= '0;
        stall_q <= '0;
      end else if (CDPERFCLR) begin
        flit_q  <= '0;
        stall_q <= '0;
      end else begin
        if (valid_q && CDOREADY[o] && !(&flit_q))  flit_q  <= flit_q + 32'd1;
        if (valid_q && !CDOREADY[o] && !(&stall_q)) stall_q <= stall_q + 32'd1;
      end
    end

    assign CDPERFFLIT[o*32 +: 32]  = flit_q;
    assign CDPERFSTALL[o*32 +: 32] = stall_q;
`endif
  end

endmodule

// File: tb/tb_mesh_router_buf.sv
`timescale 1ns/1ps
module tb_mesh_router_buf;

  localparam int DW = 16;
  localparam int NP = 5;
  localparam int PW = 0, PE = 1, PN = 2, PS = 3, PL = 4;
  localparam int MX = 2, MY = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP*DW-1:0] idata = '0;
  logic [NP-1:0]   ivalid = '0;
  logic [NP-1:0]   iready;
  logic [NP*DW-1:0] odata;
  logic [NP-1:0]   ovalid;
  logic [NP-1:0]   oready = '1;
`ifdef MESH_ROUTER_PERF_EN
  logic [NP*32-1:0] pflit, pstall;
  logic             pclr = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  mesh_router_buf #(
    .ROUTER_ID_X (MX),
    .ROUTER_ID_Y (MY),
    .DATA_WIDTH  (DW),
    .COORD_W     (4),
    .DEPTH       (4)
  ) dut (
    .CDCLK    (clk),
    .CDRESETn (rst_n),
    .CDIDATA  (idata),
    .CDIVALID (ivalid),
    .CDIREADY (iready),
    .CDODATA  (odata),
    .CDOVALID (ovalid),
    .CDOREADY (oready)
`ifdef MESH_ROUTER_PERF_EN
    ,
    .CDPERFFLIT  (pflit),
    .CDPERFSTALL (pstall),
    .CDPERFCLR   (pclr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Flit layout: [15:12] dest X, [11:8] dest Y, [7:5] source port, [4:0] sequence.
  function automatic logic [15:0] mk(input int dx, input int dy, input int src, input int seq);
    return {4'(dx), 4'(dy), 3'(src), 5'(seq)};
  endfunction

  function automatic int route(input logic [15:0] f);
    int dx, dy;
    dx = int'(f[15:12]);
    dy = int'(f[11:8]);
    if (dx > MX) return PE;
    if (dx < MX) return PW;
    if (dy > MY) return PS;
    if (dy < MY) return PN;
    return PL;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input int p, input logic [15:0] f);
    tick();
    ivalid[p] = 1'b1;
    idata[p*DW +: DW] = f;
    tick();
    ivalid[p] = 1'b0;
  endtask

  task automatic expect_out(input int o, input logic [15:0] f, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!ovalid[o] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(ovalid[o]), 32'd1);
    chk({tag, "_data"}, 32'(odata[o*DW +: DW]), 32'(f));
  endtask

  task automatic reset_pulse();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard: one queue per (source, destination-output) pair; only the
  // per-pair order is guaranteed by the router.
  logic [15:0] sbq [NP*NP][$];
  bit          mon_en = 1'b0;
  logic [NP-1:0] pv, pr;
  logic [15:0] pd [NP];
  int pushed = 0, popped = 0;

  always @(negedge clk) begin
    logic [15:0] mf, ef;
    int src;
    if (mon_en) begin
      for (int p = 0; p < NP; p++) begin
        if (ivalid[p] && iready[p]) begin
          mf = idata[p*DW +: DW];
          sbq[p*NP + route(mf)].push_back(mf);
          pushed++;
        end
      end
      for (int o = 0; o < NP; o++) begin
        if (pv[o] && !pr[o])
          chk("rand_hold", {15'd0, ovalid[o], odata[o*DW +: DW]}, {15'd0, 1'b1, pd[o]});
        if (ovalid[o] && oready[o]) begin
          mf  = odata[o*DW +: DW];
          src = int'(mf[7:5]);
          chk("rand_route", 32'(o), 32'(route(mf)));
          if (src < NP && sbq[src*NP + o].size() > 0) ef = sbq[src*NP + o].pop_front();
          else ef = 'x;
          chk("rand_order", 32'(mf), 32'(ef));
          popped++;
        end
        pv[o] = ovalid[o];
        pr[o] = oready[o];
        pd[o] = odata[o*DW +: DW];
      end
    end
  end

  initial begin
    logic [15:0] f;
    logic [15:0] got [$];
    logic [NP-1:0] acc;
    int n, k, cnt, stale, left;
    int seqc [NP];
    bit adv;
    int order_src [8];

    // ---------------- reset values
    #12;
    chk("rst_ovalid", 32'(ovalid), 32'd0);
    chk("rst_odata_lo", odata[31:0], 32'd0);
    chk("rst_iready", 32'(iready), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_iready", 32'(iready), 32'h1f);

    // ---------------- latency W -> E
    tick();
    f = mk(3, 2, PW, 1);
    ivalid[PW] = 1'b1;
    idata[PW*DW +: DW] = f;
    @(negedge clk);
    chk("lat_ready", 32'(iready[PW]), 32'd1);
    tick();
    ivalid[PW] = 1'b0;
    @(negedge clk);
    chk("lat_t1_ovalid", 32'(ovalid), 32'd0);
    @(negedge clk);
    chk("lat_t2_ovalid", 32'(ovalid), 32'b00010);
    chk("lat_t2_data", 32'(odata[PE*DW +: DW]), 32'(f));

    // ---------------- routing cases
    send_one(PN, mk(2, 2, PN, 2));
    expect_out(PL, mk(2, 2, PN, 2), "route_N_to_L");
    send_one(PL, mk(2, 0, PL, 3));
    expect_out(PN, mk(2, 0, PL, 3), "route_L_to_N");
    send_one(PE, mk(0, 3, PE, 4));
    expect_out(PW, mk(0, 3, PE, 4), "route_E_to_W");
    send_one(PL, mk(2, 3, PL, 5));
    expect_out(PS, mk(2, 3, PL, 5), "route_L_to_S");

    // ---------------- round robin on E from pointer 0
    reset_pulse();
    tick();
    for (int p = 0; p < NP; p++) if (p != PE) begin
      ivalid[p] = 1'b1;
      idata[p*DW +: DW] = mk(3, 2, p, 0);
    end
    tick();
    for (int p = 0; p < NP; p++) if (p != PE) idata[p*DW +: DW] = mk(3, 2, p, 1);
    tick();
    ivalid = '0;
    got.delete();
    n = 0;
    while (got.size() < 8 && n < 40) begin
      @(negedge clk);
      if (ovalid[PE]) got.push_back(odata[PE*DW +: DW]);
      n++;
    end
    order_src = '{PW, PN, PS, PL, PW, PN, PS, PL};
    chk("rr_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      f = (i < got.size()) ? got[i] : 16'hxxxx;
      chk($sformatf("rr_slot%0d", i), 32'(f), 32'(mk(3, 2, order_src[i], i / 4)));
    end

    // ---------------- backpressure: 1 in output reg + DEPTH in FIFO
    tick();
    oready[PE] = 1'b0;
    k = 0;
    cnt = 0;
    ivalid[PW] = 1'b1;
    idata[PW*DW +: DW] = mk(3, 2, PW, 0);
    repeat (12) begin
      @(negedge clk);
      adv = ivalid[PW] && iready[PW];
      if (adv) cnt++;
      tick();
      if (adv) begin
        k++;
        idata[PW*DW +: DW] = mk(3, 2, PW, k);
      end
    end
    ivalid[PW] = 1'b0;
    @(negedge clk);
    chk("bp_accepts", 32'(cnt), 32'd5);
    chk("bp_iready_w", 32'(iready[PW]), 32'd0);
    chk("bp_hold_valid", 32'(ovalid[PE]), 32'd1);
    chk("bp_hold_data", 32'(odata[PE*DW +: DW]), 32'(mk(3, 2, PW, 0)));
    tick();
    oready[PE] = 1'b1;
    got.delete();
    n = 0;
    while (got.size() < 5 && n < 30) begin
      @(negedge clk);
      if (ovalid[PE]) got.push_back(odata[PE*DW +: DW]);
      n++;
    end
    chk("bp_drain_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      f = (i < got.size()) ? got[i] : 16'hxxxx;
      chk($sformatf("bp_drain%0d", i), 32'(f), 32'(mk(3, 2, PW, i)));
    end

    // ---------------- reset with flits buffered
    tick();
    oready = '0;
    ivalid[PW] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idata[PW*DW +: DW] = mk(3, 2, PW, 20 + i);
      tick();
    end
    ivalid[PW] = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("mid_pre_valid", 32'(ovalid[PE]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovalid", 32'(ovalid), 32'd0);
    chk("mid_rst_iready", 32'(iready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    oready = '1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (ovalid != '0) stale++;
    end
    chk("mid_no_stale", 32'(stale), 32'd0);
    chk("mid_iready", 32'(iready), 32'h1f);

    // ---------------- randomized traffic against the scoreboard
    for (int i = 0; i < NP*NP; i++) sbq[i].delete();
    for (int p = 0; p < NP; p++) seqc[p] = 0;
    pv = '0;
    pr = '0;
    tick();
    mon_en = 1'b1;
    acc = '0;
    repeat (800) begin
      @(negedge clk);
      acc = ivalid & iready;
      tick();
      for (int p = 0; p < NP; p++) begin
        if (!ivalid[p] || acc[p]) begin
          if ($urandom_range(0, 99) < 55) begin
            ivalid[p] = 1'b1;
            idata[p*DW +: DW] = mk($urandom_range(0, 4), $urandom_range(0, 4), p, seqc[p]);
            seqc[p]++;
          end else begin
            ivalid[p] = 1'b0;
          end
        end
      end
      for (int o = 0; o < NP; o++) oready[o] = ($urandom_range(0, 99) < 70);
    end
    @(negedge clk);
    tick();
    ivalid = '0;
    oready = '1;
    repeat (40) @(negedge clk);
    mon_en = 1'b0;
    left = 0;
    for (int i = 0; i < NP*NP; i++) left += sbq[i].size();
    chk("rand_leftover", 32'(left), 32'd0);
    chk("rand_balance", 32'(popped), 32'(pushed));

`ifdef MESH_ROUTER_PERF_EN
    // ---------------- performance counters
    reset_pulse();
    tick();
    oready = '1;
    oready[PE] = 1'b0;
    cnt = 0;
    stale = 0;
    k = 0;
    n = 0;
    ivalid[PW] = 1'b1;
    idata[PW*DW +: DW] = mk(3, 2, PW, 0);
    while (cnt < 10 && n < 100) begin
      @(negedge clk);
      adv = ivalid[PW] && iready[PW];
      if (ovalid[PE] && !oready[PE]) stale++;
      if (ovalid[PE] && oready[PE]) cnt++;
      tick();
      n++;
      if (adv) begin
        k++;
        if (k < 10) idata[PW*DW +: DW] = mk(3, 2, PW, k);
        else ivalid[PW] = 1'b0;
      end
      oready[PE] = (stale >= 3);
    end
    @(negedge clk);
    chk("perf_bench_flits", 32'(cnt), 32'd10);
    chk("perf_bench_stalls", 32'(stale), 32'd3);
    chk("perf_flit_e", pflit[PE*32 +: 32], 32'd10);
    chk("perf_stall_e", pstall[PE*32 +: 32], 32'd3);
    chk("perf_flit_w", pflit[PW*32 +: 32], 32'd0);
    tick();
    pclr = 1'b1;
    tick();
    pclr = 1'b0;
    @(negedge clk);
    chk("perf_clr_flit", pflit[PE*32 +: 32], 32'd0);
    chk("perf_clr_stall", pstall[PE*32 +: 32], 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
